// File: rtl/nes_i2c_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nes_i2c_target_pkg
// Description : Shared constants for the NES Classic I2C target: FSM state
//               encodings, joypad bit positions and the register-map function.
// Revision    : 1.0 - initial release
// ============================================================================
package nes_i2c_target_pkg;

    localparam int NUM_BYTES_DEFAULT = 6;

    // Joypad bit positions, matching the nes_bridge JOYP_* layout.
    localparam int JOYP_A      = 0;
    localparam int JOYP_B      = 1;
    localparam int JOYP_SELECT = 2;
    localparam int JOYP_START  = 3;
    localparam int JOYP_UP     = 4;
    localparam int JOYP_DOWN   = 5;
    localparam int JOYP_LEFT   = 6;
    localparam int JOYP_RIGHT  = 7;

    localparam logic [7:0] BTN_BYTE_0 = 8'd4;
    localparam logic [7:0] BTN_BYTE_1 = 8'd5;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ADDR       = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK   = 3'd2;
    localparam logic [2:0] ST_WRITE_BYTE = 3'd3;
    localparam logic [2:0] ST_WRITE_ACK  = 3'd4;
    localparam logic [2:0] ST_READ_BYTE  = 3'd5;
    localparam logic [2:0] ST_READ_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE     = 3'd7;

    function automatic logic [7:0] reg_byte(input logic [7:0] idx, input logic [7:0] joy);
        logic [7:0] v;
        v = 8'h00;
        if (idx == BTN_BYTE_0) begin
            v[7] = joy[JOYP_RIGHT];
            v[6] = joy[JOYP_DOWN];
            v[4] = joy[JOYP_SELECT];
            v[2] = joy[JOYP_START];
        end else if (idx == BTN_BYTE_1) begin
            v[6] = joy[JOYP_B];
            v[4] = joy[JOYP_A];
            v[1] = joy[JOYP_LEFT];
            v[0] = joy[JOYP_UP];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nes_i2c_target_phy.sv
`default_nettype none
// ============================================================================
// Module      : i2c_target_phy
// Description : SCL/SDA synchronizers, edge detection and START/STOP detection.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_target_phy (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic r_scl_meta, r_scl_s, r_scl_p;
    logic r_sda_meta, r_sda_s, r_sda_p;

    // Idle bus is high, so everything resets to 1 to avoid a fake edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_meta <= 1'b1;
            r_scl_s    <= 1'b1;
            r_scl_p    <= 1'b1;
            r_sda_meta <= 1'b1;
            r_sda_s    <= 1'b1;
            r_sda_p    <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;
            r_scl_s    <= r_scl_meta;
            r_scl_p    <= r_scl_s;
            r_sda_meta <= sda_in;
            r_sda_s    <= r_sda_meta;
            r_sda_p    <= r_sda_s;
        end
    end

    assign scl_rise  =  r_scl_s & ~r_scl_p;
    assign scl_fall  = ~r_scl_s &  r_scl_p;
    assign start_det =  r_scl_s &  r_sda_p & ~r_sda_s;
    assign stop_det  =  r_scl_s & ~r_sda_p &  r_sda_s;
    assign sda_s     =  r_sda_s;

endmodule
`default_nettype wire

// File: rtl/nes_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : nes_i2c_target
// Description : I2C target emulating the NES Classic controller register window.
// Revision    : 1.0 - initial release
// ============================================================================
module nes_i2c_target
    import nes_i2c_target_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h52,
    parameter int         NUM_BYTES  = NUM_BYTES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    input  logic [7:0] joypad,
    output logic       busy,
    output logic       init_seen,
    output logic       read_done
);

    localparam int         PTR_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [7:0] NUM_B     = 8'(NUM_BYTES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_BYTES - 1);

    logic w_scl_rise, w_scl_fall, w_start_det, w_stop_det, w_sda_s;

    i2c_target_phy u_phy (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (w_scl_rise),
        .scl_fall  (w_scl_fall),
        .start_det (w_start_det),
        .stop_det  (w_stop_det),
        .sda_s     (w_sda_s)
    );

    logic [2:0]       r_state;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_tx;
    logic [7:0]       r_snapshot;
    logic [PTR_W-1:0] r_pointer;
    logic             r_rw;
    logic             r_first;
    logic             r_sda_out;
    logic             r_busy;
    logic             r_init_seen;
    logic             r_read_done;

    logic [7:0]       w_next_byte;
    logic             w_addr_match;

    assign w_next_byte  = reg_byte(8'(r_pointer), r_snapshot);
    assign w_addr_match = (r_shift[7:1] == SLAVE_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_tx        <= 8'h00;
            r_snapshot  <= 8'h00;
            r_pointer   <= '0;
            r_rw        <= 1'b0;
            r_first     <= 1'b0;
            r_sda_out   <= 1'b1;
            r_busy      <= 1'b0;
            r_init_seen <= 1'b0;
            r_read_done <= 1'b0;
        end else begin
            r_init_seen <= 1'b0;
            r_read_done <= 1'b0;
            // Bus conditions override whatever the FSM was doing.
            if (w_start_det) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_out <= 1'b1;
                r_busy    <= 1'b0;
            end else if (w_stop_det) begin
                r_state   <= ST_IDLE;
                r_sda_out <= 1'b1;
                r_busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            if (w_addr_match) begin
                                r_sda_out <= 1'b0;
                                r_busy    <= 1'b1;
                                r_rw      <= r_shift[0];
                                r_first   <= 1'b1;
                                r_state   <= ST_ADDR_ACK;
                                if (r_shift[0]) begin
                                    r_snapshot <= joypad;
                                end
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (r_rw) begin
                                r_sda_out <= w_next_byte[7];
                                r_tx      <= {w_next_byte[6:0], 1'b0};
                                r_bit_cnt <= 4'd1;
                                r_state   <= ST_READ_BYTE;
                            end else begin
                                r_sda_out <= 1'b1;
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_WRITE_BYTE;
                            end
                        end
                    end
                    ST_WRITE_BYTE: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], w_sda_s};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_sda_out <= 1'b0;
                            r_state   <= ST_WRITE_ACK;
                            // Only the first data byte is a register pointer.
                            if (r_first) begin
                                r_first     <= 1'b0;
                                r_pointer   <= (r_shift < NUM_B) ? PTR_W'(r_shift) : '0;
                                r_init_seen <= (r_shift == 8'h00);
                            end
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_out <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_WRITE_BYTE;
                        end
                    end
                    ST_READ_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_out <= 1'b1;
                                r_state   <= ST_READ_ACK;
                                r_pointer <= (r_pointer == PTR_LAST) ? '0 : r_pointer + 1'b1;
                            end else begin
                                r_sda_out <= r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        if (w_scl_rise && w_sda_s) begin
                            r_read_done <= 1'b1;
                            r_sda_out   <= 1'b1;
                            r_state     <= ST_IGNORE;
                        end else if (w_scl_fall) begin
                            r_sda_out <= w_next_byte[7];
                            r_tx      <= {w_next_byte[6:0], 1'b0};
                            r_bit_cnt <= 4'd1;
                            r_state   <= ST_READ_BYTE;
                        end
                    end
                    default: begin
                        r_sda_out <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign sda_out   = r_sda_out;
    assign busy      = r_busy;
    assign init_seen = r_init_seen;
    assign read_done = r_read_done;

endmodule
`default_nettype wire

// File: tb/tb_nes_i2c_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_nes_i2c_target
// Description : Bit-banged I2C master bench with a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_i2c_target;

    localparam int Q = 5;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] joypad = 8'h00;
    logic       sda_out, busy, init_seen, read_done;
    wire        sda_line = sda_m & sda_out;

    int total = 0;
    int bad = 0;
    int init_cnt = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    int busy_cnt = 0;
    bit mon_en = 1'b0;
    int model_ptr = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx [0:15];

    always #10 clk = ~clk;

    nes_i2c_target dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_out   (sda_out),
        .joypad    (joypad),
        .busy      (busy),
        .init_seen (init_seen),
        .read_done (read_done)
    );

    always @(negedge clk) begin
        if (init_seen) init_cnt++;
        if (read_done) done_cnt++;
        if (mon_en && !sda_out) low_cnt++;
        if (mon_en && busy) busy_cnt++;
    end

    // Expected register contents, written from the controller's point of view.
    function automatic logic [7:0] exp_byte(input int idx, input logic [7:0] j);
        logic [7:0] v;
        v = 8'h00;
        if (idx == 4) v = (j[7] ? 8'h80 : 8'h00) | (j[5] ? 8'h40 : 8'h00)
                        | (j[2] ? 8'h10 : 8'h00) | (j[3] ? 8'h04 : 8'h00);
        if (idx == 5) v = (j[1] ? 8'h40 : 8'h00) | (j[0] ? 8'h10 : 8'h00)
                        | (j[6] ? 8'h02 : 8'h00) | (j[4] ? 8'h01 : 8'h00);
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1;
        tick(H); sda_m = 1'b0; tick(H); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b1;
        tick(H); sda_m = 1'b1; tick(H);
    endtask

    task automatic write_bit(input logic b);
        tick(Q); sda_m = b; tick(Q); scl = 1'b1; tick(H); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); b = sda_line; tick(Q); scl = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) read_bit(v[i]);
        write_bit(nack);
    endtask

    task automatic write_ptr(input logic [7:0] p);
        logic a;
        i2c_start();
        write_byte(8'hA4, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        write_byte(p, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL wr_data_ack: got %b want 0", a); end
        i2c_stop();
        model_ptr = (p < 8'd6) ? int'(p) : 0;
    endtask

    // Read n bytes; after byte change_after the joypad is switched to new_joy.
    task automatic do_read(input int n, input int change_after, input logic [7:0] new_joy);
        logic a;
        logic [7:0] v, e;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(exp_byte(model_ptr, joypad));
            model_ptr = (model_ptr == 5) ? 0 : model_ptr + 1;
        end
        i2c_start();
        write_byte(8'hA5, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_set: got %b want 1", busy); end
        for (int i = 0; i < n; i++) begin
            read_byte((i == n - 1), v);
            rx[i] = v;
            if (i == change_after) joypad = new_joy;
            e = exp_q.pop_front();
            total++;
            if (v !== e) begin bad++; $display("FAIL rd_byte%0d: got %h want %h", i, v, e); end
        end
        i2c_stop();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_clr: got %b want 0", busy); end
    endtask

    task automatic test_reset();
        total++; if (sda_out !== 1'b1) begin bad++; $display("FAIL rst_sda: got %b want 1", sda_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (init_seen !== 1'b0) begin bad++; $display("FAIL rst_init: got %b want 0", init_seen); end
        total++; if (read_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", read_done); end
    endtask

    task automatic test_bridge();
        int i0, d0;
        logic [7:0] dec;
        i0 = init_cnt; d0 = done_cnt;
        joypad = 8'hA5;
        write_ptr(8'h00);
        do_read(6, -1, 8'h00);
        dec = {rx[4][7], rx[5][1], rx[4][6], rx[5][0], rx[4][2], rx[4][4], rx[5][6], rx[5][4]};
        total++; if (dec !== 8'hA5) begin bad++; $display("FAIL bridge_joy: got %h want a5", dec); end
        total++; if (init_cnt - i0 != 1) begin bad++; $display("FAIL init_pulses: got %0d want 1", init_cnt - i0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wrong_addr();
        logic a;
        int i0;
        i0 = init_cnt;
        low_cnt = 0; busy_cnt = 0; mon_en = 1'b1;
        i2c_start();
        write_byte(8'hA6, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL nack_addr: got %b want 1", a); end
        write_byte(8'h00, a);
        i2c_stop();
        mon_en = 1'b0;
        total++; if (low_cnt != 0) begin bad++; $display("FAIL nack_sda_low: got %0d want 0", low_cnt); end
        total++; if (busy_cnt != 0) begin bad++; $display("FAIL nack_busy: got %0d want 0", busy_cnt); end
        total++; if (init_cnt != i0) begin bad++; $display("FAIL nack_init: got %0d want %0d", init_cnt, i0); end
    endtask

    task automatic test_ptr_read();
        logic a;
        joypad = 8'h81;
        write_ptr(8'h04);
        // Address-only write: pointer must survive.
        i2c_start();
        write_byte(8'hA4, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL zero_wr_ack: got %b want 0", a); end
        i2c_stop();
        do_read(2, -1, 8'h00);
        total++; if (rx[0] !== 8'h80) begin bad++; $display("FAIL right_byte: got %h want 80", rx[0]); end
        total++; if (rx[1] !== 8'h10) begin bad++; $display("FAIL a_byte: got %h want 10", rx[1]); end
        do_read(5, -1, 8'h00);
        total++; if (rx[4] !== 8'h80) begin bad++; $display("FAIL ptr_wrapped: got %h want 80", rx[4]); end
        write_ptr(8'h09);
        do_read(1, -1, 8'h00);
    endtask

    task automatic test_wrap();
        joypad = 8'hFF;
        write_ptr(8'h00);
        do_read(8, -1, 8'h00);
    endtask

    task automatic test_snapshot();
        joypad = 8'h00;
        write_ptr(8'h03);
        do_read(3, 0, 8'hFF);
    endtask

    task automatic test_async_reset();
        logic a;
        joypad = 8'h00;
        write_ptr(8'h00);
        i2c_start();
        write_byte(8'hA5, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL ar_addr_ack: got %b want 0", a); end
        tick(4);
        total++; if (sda_out !== 1'b0) begin bad++; $display("FAIL ar_driving: got %b want 0", sda_out); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (sda_out !== 1'b1) begin bad++; $display("FAIL ar_release: got %b want 1", sda_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", busy); end
        tick(2);
        rst_n = 1'b1;
        model_ptr = 0;
        i2c_stop();
        joypad = 8'h5A;
        do_read(6, -1, 8'h00);
    endtask

    initial begin
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(5);
        test_bridge();
        test_wrong_addr();
        test_ptr_read();
        test_wrap();
        test_snapshot();
        test_async_reset();
        tick(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
